// File: rtl/cam_capture_addr_gen.sv
// Camera capture write-address generator.
// Assembles OV7670 RGB565 byte pairs and decimates the 640x480 stream 2:1 in
// both directions. Each kept pixel becomes one RGB444 write into a 320x240
// frame buffer.
// Ports:
//   clk        camera pixel clock (PCLK), rising edge
//   rst        asynchronous active-low reset
//   vsync      camera VSYNC, high during vertical blanking
//   href       camera HREF, high while active bytes are on d
//   d          camera data byte
//   pixel_addr frame-buffer write address (holds its last written value)
//   wdata      RGB444 write data
//   wea        one-cycle write strobe per stored pixel
//   frame_done one-cycle pulse when a captured frame ends
module cam_capture_addr_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned FB_WIDTH = H_ACTIVE / 2,
    parameter int unsigned FB_DEPTH = FB_WIDTH * (V_ACTIVE / 2)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vsync,
    input  logic        href,
    input  logic [7:0]  d,
    output logic [16:0] pixel_addr,
    output logic [11:0] wdata,
    output logic        wea,
    output logic        frame_done
);

    localparam int unsigned AW = 17;
    localparam int unsigned CW = 11;
    localparam int unsigned RW = 10;
    localparam int unsigned PW = 12;

    typedef enum logic [0:0] {
        WAIT_FRAME = 1'b0,
        CAPTURE    = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic            vsync_q, href_q;
    logic            phase_q, phase_d;
    logic [7:0]      hi_q, hi_d;
    logic [CW-1:0]   col_q, col_d;
    logic [RW-1:0]   row_q, row_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic            full_q, full_d;
    logic [AW-1:0]   pixel_addr_q, pixel_addr_d;
    logic [PW-1:0]   wdata_q, wdata_d;
    logic            wea_q, wea_d;
    logic            frame_done_q, frame_done_d;

    logic vsync_rise, vsync_fall, href_fall, keep;

    // Edges compare the live input against its one-cycle-delayed copy.
    assign vsync_rise = vsync & ~vsync_q;
    assign vsync_fall = ~vsync & vsync_q;
    assign href_fall  = ~href & href_q;

    // Store only even col / even row inside the active window, until the buffer is full.
    assign keep = ~col_q[0] && ~row_q[0] &&
                  (col_q < CW'(H_ACTIVE)) && (row_q < RW'(V_ACTIVE)) && ~full_q;

    // Next-state and output logic.
    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        hi_d         = hi_q;
        col_d        = col_q;
        row_d        = row_q;
        addr_d       = addr_q;
        full_d       = full_q;
        pixel_addr_d = pixel_addr_q;
        wdata_d      = wdata_q;
        wea_d        = 1'b0;
        frame_done_d = 1'b0;

        case (state_q)
            WAIT_FRAME: begin
                if (vsync_fall) begin
                    col_d   = '0;
                    row_d   = '0;
                    phase_d = 1'b0;
                    addr_d  = '0;
                    full_d  = 1'b0;
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                // vsync wins over a coincident href fall; the open line is dropped.
                if (vsync_rise) begin
                    frame_done_d = 1'b1;
                    phase_d      = 1'b0;
                    state_d      = WAIT_FRAME;
                end else if (href) begin
                    if (!phase_q) begin
                        hi_d    = d;
                        phase_d = 1'b1;
                    end else begin
                        phase_d = 1'b0;
                        if (col_q < CW'(H_ACTIVE)) begin
                            col_d = col_q + CW'(1);
                        end
                        if (keep) begin
                            wea_d        = 1'b1;
                            pixel_addr_d = addr_q;
                            // RGB565 {hi,d} -> R[4:1], G[5:2], B[4:1]
                            wdata_d      = {hi_q[7:4], hi_q[2:0], d[7], d[4:1]};
                            if (addr_q == AW'(FB_DEPTH - 1)) begin
                                full_d = 1'b1;
                            end else begin
                                addr_d = addr_q + AW'(1);
                            end
                        end
                    end
                end else if (href_fall) begin
                    phase_d = 1'b0;
                    col_d   = '0;
                    if (row_q < RW'(V_ACTIVE)) begin
                        row_d = row_q + RW'(1);
                    end
                end
            end
            default: state_d = WAIT_FRAME;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= WAIT_FRAME;
            vsync_q      <= 1'b0;
            href_q       <= 1'b0;
            phase_q      <= 1'b0;
            hi_q         <= '0;
            col_q        <= '0;
            row_q        <= '0;
            addr_q       <= '0;
            full_q       <= 1'b0;
            pixel_addr_q <= '0;
            wdata_q      <= '0;
            wea_q        <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            vsync_q      <= vsync;
            href_q       <= href;
            phase_q      <= phase_d;
            hi_q         <= hi_d;
            col_q        <= col_d;
            row_q        <= row_d;
            addr_q       <= addr_d;
            full_q       <= full_d;
            pixel_addr_q <= pixel_addr_d;
            wdata_q      <= wdata_d;
            wea_q        <= wea_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign pixel_addr = pixel_addr_q;
    assign wdata      = wdata_q;
    assign wea        = wea_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_cam_capture_addr_gen.sv
// Directed bench for cam_capture_addr_gen, using a scaled-down 16x12 source
// frame (8x6 frame buffer, 48 entries) to keep the run short.
module tb_cam_capture_addr_gen;

    localparam int unsigned H   = 16;
    localparam int unsigned V   = 12;
    localparam int unsigned FBW = 8;
    localparam int unsigned FBD = 48;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        vsync = 1'b1;
    logic        href = 1'b0;
    logic [7:0]  d = 8'h00;
    logic [16:0] pixel_addr;
    logic [11:0] wdata;
    logic        wea;
    logic        frame_done;

    int total = 0;
    int bad   = 0;
    int nfd   = 0;
    logic [16:0] wa[$];
    logic [11:0] wd[$];

    cam_capture_addr_gen #(
        .H_ACTIVE(H), .V_ACTIVE(V), .FB_WIDTH(FBW), .FB_DEPTH(FBD)
    ) dut (
        .clk(clk), .rst(rst), .vsync(vsync), .href(href), .d(d),
        .pixel_addr(pixel_addr), .wdata(wdata), .wea(wea), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // Write/frame_done monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (wea === 1'b1) begin
            wa.push_back(pixel_addr);
            wd.push_back(wdata);
        end
        if (frame_done === 1'b1) nfd++;
    end

    function automatic logic [11:0] to444(input logic [15:0] w);
        logic [4:0] r5;
        logic [5:0] g6;
        logic [4:0] b5;
        r5 = w[15:11];
        g6 = w[10:5];
        b5 = w[4:0];
        return {r5[4:1], g6[5:2], b5[4:1]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic v, input logic h, input logic [7:0] dd);
        vsync = v;
        href  = h;
        d     = dd;
        @(posedge clk);
        #1;
    endtask

    task automatic frame_start();
        step(1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00);
    endtask

    task automatic frame_end();
        step(1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b0, 8'h00);
    endtask

    // One line of npix pixels, word = {row, col}; optional dangling byte.
    task automatic send_line(input int row, input int npix, input bit odd);
        logic [15:0] w;
        for (int c = 0; c < npix; c++) begin
            w = {8'(row), 8'(c)};
            step(1'b0, 1'b1, w[15:8]);
            step(1'b0, 1'b1, w[7:0]);
        end
        if (odd) step(1'b0, 1'b1, 8'hAA);
        step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00);
    endtask

    task automatic clear_log();
        wa.delete();
        wd.delete();
    endtask

    // Compare logged writes against the ideal decimated frame.
    task automatic check_frame(input string tag, input int nexp);
        int r;
        int c;
        chk({tag, "_nwr"}, 32'(wa.size()), 32'(nexp));
        for (int i = 0; i < wa.size() && i < nexp; i++) begin
            r = 2 * (i / FBW);
            c = 2 * (i % FBW);
            chk($sformatf("%s_addr%0d", tag, i), 32'(wa[i]), 32'(i));
            chk($sformatf("%s_data%0d", tag, i), 32'(wd[i]), 32'(to444({8'(r), 8'(c)})));
        end
    endtask

    task automatic full_frame(input int nlines);
        frame_start();
        for (int r = 0; r < nlines; r++) send_line(r, H, 1'b0);
        frame_end();
    endtask

    initial begin
        int fd0;

        // Reset values
        #1;
        chk("rst_addr", 32'(pixel_addr), 32'd0);
        chk("rst_wdata", 32'(wdata), 32'd0);
        chk("rst_wea", 32'(wea), 32'd0);
        chk("rst_fd", 32'(frame_done), 32'd0);
        step(1'b1, 1'b0, 8'h00);
        rst = 1'b1;
        step(1'b1, 1'b0, 8'h00);

        // Full well-formed frame
        clear_log();
        fd0 = nfd;
        full_frame(V);
        check_frame("full", FBD);
        chk("full_fd", 32'(nfd - fd0), 32'd1);
        chk("full_hold_addr", 32'(pixel_addr), 32'(FBD - 1));
        if (wa.size() > 8) chk("full_src02_addr", 32'(wa[FBW]), 32'(FBW));

        // Single pixel: red+blue, 1-cycle latency
        clear_log();
        frame_start();
        step(1'b0, 1'b1, 8'hF8);
        chk("px_wea_early", 32'(wea), 32'd0);
        step(1'b0, 1'b1, 8'h1F);
        chk("px_wea", 32'(wea), 32'd1);
        chk("px_wdata", 32'(wdata), 32'hF0F);
        chk("px_addr", 32'(pixel_addr), 32'd0);
        step(1'b0, 1'b0, 8'h00);
        chk("px_wea_off", 32'(wea), 32'd0);
        chk("px_addr_hold", 32'(pixel_addr), 32'd0);
        step(1'b0, 1'b0, 8'h00);
        frame_end();
        chk("px_nwr", 32'(wa.size()), 32'd1);

        // Overlong line with dangling byte, then normal lines
        clear_log();
        fd0 = nfd;
        frame_start();
        send_line(0, H + 1, 1'b1);
        for (int r = 1; r < V; r++) send_line(r, H, 1'b0);
        frame_end();
        check_frame("long", FBD);
        chk("long_fd", 32'(nfd - fd0), 32'd1);

        // Extra lines beyond V_ACTIVE
        clear_log();
        fd0 = nfd;
        full_frame(V + 2);
        check_frame("tall", FBD);
        chk("tall_fd", 32'(nfd - fd0), 32'd1);
        chk("tall_last", 32'(pixel_addr), 32'(FBD - 1));

        // vsync rising mid-line (line 5), href still high
        clear_log();
        fd0 = nfd;
        frame_start();
        for (int r = 0; r < 5; r++) send_line(r, H, 1'b0);
        step(1'b0, 1'b1, 8'h12);
        step(1'b0, 1'b1, 8'h34);
        step(1'b0, 1'b1, 8'h56);
        step(1'b1, 1'b1, 8'h78);
        step(1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b0, 8'h00);
        check_frame("abort", 3 * FBW);
        chk("abort_fd", 32'(nfd - fd0), 32'd1);
        clear_log();
        full_frame(V);
        check_frame("after_abort", FBD);

        // Asynchronous reset mid-line
        clear_log();
        fd0 = nfd;
        frame_start();
        for (int r = 0; r < 3; r++) send_line(r, H, 1'b0);
        step(1'b0, 1'b1, 8'h03);
        step(1'b0, 1'b1, 8'h00);
        chk("prerst_addr", 32'(pixel_addr), 32'(2 * FBW - 1));
        #2 rst = 1'b0;
        #1;
        chk("arst_addr", 32'(pixel_addr), 32'd0);
        chk("arst_wdata", 32'(wdata), 32'd0);
        chk("arst_wea", 32'(wea), 32'd0);
        step(1'b0, 1'b1, 8'h03);
        step(1'b0, 1'b1, 8'h02);
        rst = 1'b1;
        clear_log();
        for (int r = 3; r < V; r++) send_line(r, H, 1'b0);
        frame_end();
        chk("postrst_nwr", 32'(wa.size()), 32'd0);
        chk("postrst_fd", 32'(nfd - fd0), 32'd0);
        clear_log();
        full_frame(V);
        check_frame("resync", FBD);
        chk("resync_fd", 32'(nfd - fd0), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
